// File: rtl/request_unit.sv
// Request sequencer: issues one instruction fetch, then at most one data access,
// holding each memory request until its hit; produces pcEN, sticky halt and error flags.
module request_unit #(
  parameter int TIMEOUT = 64,
  parameter int STALL_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cu_iREN,
  input  logic               cu_dREN,
  input  logic               cu_dWEN,
  input  logic               cu_halt,
  input  logic               ihit,
  input  logic               dhit,
  output logic               imemREN,
  output logic               dmemREN,
  output logic               dmemWEN,
  output logic               pcEN,
  output logic               halt,
  output logic               err_timeout,
  output logic               err_conflict,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               d_rd_q, d_rd_d;
  logic               d_wr_q, d_wr_d;
  logic               err_conflict_q, err_conflict_d;
  logic               err_timeout_q, err_timeout_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic imem_c, dren_c, dwen_c, pc_c, waiting_c, hit_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= FETCH;
      d_rd_q         <= 1'b0;
      d_wr_q         <= 1'b0;
      err_conflict_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      wait_q         <= '0;
      stall_q        <= '0;
    end else begin
      state_q        <= state_d;
      d_rd_q         <= d_rd_d;
      d_wr_q         <= d_wr_d;
      err_conflict_q <= err_conflict_d;
      err_timeout_q  <= err_timeout_d;
      wait_q         <= wait_d;
      stall_q        <= stall_d;
    end
  end

  // A halt on the fetched instruction takes precedence over any data operation.
  always_comb begin
    state_d        = state_q;
    d_rd_d         = d_rd_q;
    d_wr_d         = d_wr_q;
    err_conflict_d = err_conflict_q;
    imem_c         = 1'b0;
    dren_c         = 1'b0;
    dwen_c         = 1'b0;
    pc_c           = 1'b0;
    waiting_c      = 1'b0;
    hit_c          = 1'b0;
    case (state_q)
      FETCH: begin
        imem_c = cu_iREN;
        if (cu_iREN && ihit) begin
          hit_c = 1'b1;
          if (cu_halt) begin
            state_d = HALTED;
          end else if (cu_dWEN || cu_dREN) begin
            d_wr_d         = cu_dWEN;
            d_rd_d         = cu_dREN && !cu_dWEN;
            err_conflict_d = err_conflict_q || (cu_dWEN && cu_dREN);
            state_d        = DATA;
          end else begin
            pc_c = 1'b1;
          end
        end else if (cu_iREN) begin
          waiting_c = 1'b1;
        end
      end
      DATA: begin
        dren_c = d_rd_q;
        dwen_c = d_wr_q;
        if (dhit) begin
          hit_c   = 1'b1;
          pc_c    = 1'b1;
          d_rd_d  = 1'b0;
          d_wr_d  = 1'b0;
          state_d = FETCH;
        end else begin
          waiting_c = 1'b1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
        d_rd_d  = 1'b0;
        d_wr_d  = 1'b0;
      end
    endcase
  end

  // Wait counter saturates at TIMEOUT so the timeout flag cannot be missed by wrap-around.
  always_comb begin
    wait_d = wait_q;
    if (hit_c || (state_d != state_q)) begin
      wait_d = '0;
    end else if (waiting_c && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    err_timeout_d = err_timeout_q || (wait_d == WAIT_MAX);
    stall_d = stall_q;
    if (waiting_c && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  assign imemREN      = imem_c && !RST;
  assign pcEN         = pc_c && !RST;
  assign dmemREN      = dren_c;
  assign dmemWEN      = dwen_c;
  assign halt         = (state_q == HALTED);
  assign err_timeout  = err_timeout_q;
  assign err_conflict = err_conflict_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_request_unit.sv
// Directed, table-driven bench for request_unit with hand-written multi-cycle sequences.
module tb_request_unit;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        CLK, RST;
  logic        cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit;
  logic        imemREN, dmemREN, dmemWEN, pcEN, halt, err_timeout, err_conflict;
  logic [31:0] stall_cnt;

  int checks;
  int failures;

  typedef struct {
    logic iren, dren, dwen, ih, dh;
    logic e_imem, e_dren, e_dwen, e_pc;
  } vec_t;

  vec_t vecs[$];

  request_unit #(.TIMEOUT(64), .STALL_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .cu_iREN(cu_iREN), .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .ihit(ihit), .dhit(dhit),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .pcEN(pcEN),
    .halt(halt), .err_timeout(err_timeout), .err_conflict(err_conflict),
    .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic addVec(input logic iren, dren, dwen, ih, dh,
                        input logic e_imem, e_dren, e_dwen, e_pc);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen; v.ih = ih; v.dh = dh;
    v.e_imem = e_imem; v.e_dren = e_dren; v.e_dwen = e_dwen; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic iren, dren, dwen, h, ih, dh);
    cu_iREN = iren; cu_dREN = dren; cu_dWEN = dwen; cu_halt = h;
    ihit = ih; dhit = dh;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic doReset();
    RST = 1'b1;
    applyStimulus(L, L, L, L, L, L);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RST = 1'b1;

    //     iren dren dwen ihit dhit | imem dren dwen pc
    addVec(H, L, L, H, L,  H, L, L, H);
    addVec(H, L, L, H, L,  H, L, L, H);
    addVec(H, L, L, L, L,  H, L, L, L);
    addVec(H, L, L, H, L,  H, L, L, H);
    addVec(L, L, L, H, L,  L, L, L, L);
    addVec(H, L, L, L, H,  H, L, L, L);
    addVec(H, H, L, H, L,  H, L, L, L);
    addVec(H, L, L, H, L,  L, H, L, L);
    addVec(H, L, L, L, L,  L, H, L, L);
    addVec(H, L, L, L, L,  L, H, L, L);
    addVec(H, L, L, L, H,  L, H, L, H);
    addVec(H, L, H, H, L,  H, L, L, L);
    addVec(H, L, L, L, H,  L, L, H, H);
    addVec(H, L, L, H, L,  H, L, L, H);

    // Reset state, with cu_iREN high to show imemREN is held low during reset.
    applyStimulus(H, L, L, L, H, L);
    checkOutput("rst_imemREN", 32'(imemREN), 32'd0);
    checkOutput("rst_pcEN", 32'(pcEN), 32'd0);
    checkOutput("rst_dmemREN", 32'(dmemREN), 32'd0);
    checkOutput("rst_dmemWEN", 32'(dmemWEN), 32'd0);
    checkOutput("rst_halt", 32'(halt), 32'd0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
    checkOutput("rst_err_conflict", 32'(err_conflict), 32'd0);
    checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
    doReset();

    // Table-driven stream: R-types, stalls, a load and a store.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iren, vecs[i].dren, vecs[i].dwen, L, vecs[i].ih, vecs[i].dh);
      checkOutput($sformatf("vec%0d_imemREN", i), 32'(imemREN), 32'(vecs[i].e_imem));
      checkOutput($sformatf("vec%0d_dmemREN", i), 32'(dmemREN), 32'(vecs[i].e_dren));
      checkOutput($sformatf("vec%0d_dmemWEN", i), 32'(dmemWEN), 32'(vecs[i].e_dwen));
      checkOutput($sformatf("vec%0d_pcEN", i), 32'(pcEN), 32'(vecs[i].e_pc));
      tick();
    end
    checkOutput("table_stall_cnt", stall_cnt, 32'd5);
    checkOutput("table_err_conflict", 32'(err_conflict), 32'd0);
    checkOutput("table_err_timeout", 32'(err_timeout), 32'd0);

    // Load with dhit after three wait cycles.
    doReset();
    applyStimulus(H, H, L, L, H, L);
    checkOutput("ld_fetch_pcEN", 32'(pcEN), 32'd0);
    tick();
    for (int j = 0; j < 3; j++) begin
      applyStimulus(H, L, L, L, L, L);
      checkOutput($sformatf("ld_wait%0d_dmemREN", j), 32'(dmemREN), 32'd1);
      checkOutput($sformatf("ld_wait%0d_imemREN", j), 32'(imemREN), 32'd0);
      checkOutput($sformatf("ld_wait%0d_pcEN", j), 32'(pcEN), 32'd0);
      tick();
    end
    applyStimulus(H, L, L, L, L, H);
    checkOutput("ld_dhit_pcEN", 32'(pcEN), 32'd1);
    checkOutput("ld_stall_cnt", stall_cnt, 32'd3);
    tick();
    applyStimulus(H, L, L, L, L, L);
    checkOutput("ld_back_imemREN", 32'(imemREN), 32'd1);
    checkOutput("ld_back_dmemREN", 32'(dmemREN), 32'd0);

    // Conflicting load+store: write wins, conflict flag sticks.
    doReset();
    applyStimulus(H, H, H, L, H, L);
    tick();
    applyStimulus(H, L, L, L, L, L);
    checkOutput("cf_dmemWEN", 32'(dmemWEN), 32'd1);
    checkOutput("cf_dmemREN", 32'(dmemREN), 32'd0);
    checkOutput("cf_err_conflict", 32'(err_conflict), 32'd1);
    applyStimulus(H, L, L, L, L, H);
    checkOutput("cf_dhit_pcEN", 32'(pcEN), 32'd1);
    tick();
    tick();
    checkOutput("cf_held_err_conflict", 32'(err_conflict), 32'd1);
    checkOutput("cf_back_imemREN", 32'(imemREN), 32'd1);

    // HALT: sticky, ignores further fetches, only RST exits.
    doReset();
    applyStimulus(H, L, L, H, H, L);
    checkOutput("ht_pcEN", 32'(pcEN), 32'd0);
    checkOutput("ht_pre_halt", 32'(halt), 32'd0);
    tick();
    for (int j = 0; j < 20; j++) begin
      applyStimulus(H, L, L, L, logic'(j % 2 == 0), L);
      checkOutput($sformatf("ht%0d_halt", j), 32'(halt), 32'd1);
      checkOutput($sformatf("ht%0d_imemREN", j), 32'(imemREN), 32'd0);
      checkOutput($sformatf("ht%0d_pcEN", j), 32'(pcEN), 32'd0);
      tick();
    end
    RST = 1'b1;
    #1;
    checkOutput("ht_rst_halt", 32'(halt), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(H, L, L, L, H, L);
    checkOutput("ht_after_imemREN", 32'(imemREN), 32'd1);
    checkOutput("ht_after_pcEN", 32'(pcEN), 32'd1);

    // Store with dhit withheld: timeout flag at the 64th wait cycle, no abort.
    doReset();
    applyStimulus(H, L, H, L, H, L);
    tick();
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(H, L, L, L, L, L);
      checkOutput($sformatf("to%0d_dmemWEN", k), 32'(dmemWEN), 32'd1);
      tick();
      if (k == 63) checkOutput("to63_err_timeout", 32'(err_timeout), 32'd0);
      if (k == 64) checkOutput("to64_err_timeout", 32'(err_timeout), 32'd1);
    end
    checkOutput("to_stall_cnt", stall_cnt, 32'd64);
    applyStimulus(H, L, L, L, L, H);
    checkOutput("to_dhit_pcEN", 32'(pcEN), 32'd1);
    tick();
    checkOutput("to_held_err_timeout", 32'(err_timeout), 32'd1);

    // Asynchronous reset in the middle of a load.
    applyStimulus(H, H, L, L, H, L);
    tick();
    applyStimulus(H, L, L, L, L, L);
    tick();
    tick();
    checkOutput("ar_pre_dmemREN", 32'(dmemREN), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("ar_dmemREN", 32'(dmemREN), 32'd0);
    checkOutput("ar_stall_cnt", stall_cnt, 32'd0);
    checkOutput("ar_err_timeout", 32'(err_timeout), 32'd0);
    checkOutput("ar_imemREN", 32'(imemREN), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(H, L, L, L, L, L);
    checkOutput("ar_after_imemREN", 32'(imemREN), 32'd1);
    checkOutput("ar_after_dmemREN", 32'(dmemREN), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Memory-side counterpart of the control unit: consumes the decoded request strobes (iREN, dREN, dWEN, halt) and drives the actual instruction/data memory requests.
- Sequences one fetch, then at most one data access per instruction, holding each request until the matching hit.
- Generates the PC-advance strobe and the sticky processor halt.
- Sits between control_unit and the memory/cache interface in the single-cycle datapath.

Parameters:
- TIMEOUT, 64, number of consecutive wait cycles on one request before err_timeout is set.
- STALL_W, 32, width of the saturating stall-cycle counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- cu_iREN  input  1  control unit requests an instruction fetch.
- cu_dREN  input  1  decoded instruction is a load.
- cu_dWEN  input  1  decoded instruction is a store.
- cu_halt  input  1  decoded instruction is HALT.
- ihit  input  1  instruction memory returned data this cycle.
- dhit  input  1  data memory completed access this cycle.
- imemREN  output  1  instruction memory read request.
- dmemREN  output  1  data memory read request.
- dmemWEN  output  1  data memory write request.
- pcEN  output  1  single-cycle strobe: PC may advance.
- halt  output  1  sticky halt to system.
- err_timeout  output  1  sticky: a request waited TIMEOUT cycles.
- err_conflict  output  1  sticky: cu_dREN and cu_dWEN were both high on an ihit.
- stall_cnt  output  STALL_W  saturating count of cycles spent waiting on a hit.

Behaviour:
- States: FETCH, DATA, HALTED. Reset state is FETCH.
- On reset, all outputs are 0, stall_cnt is 0, and the wait counter is 0.

FETCH:
- imemREN = cu_iREN; the dmem enables are 0.
- On ihit with cu_halt=1: next state HALTED, pcEN=0.
- On ihit with cu_dWEN or cu_dREN: latch the operation into registered d_wr/d_rd; next state DATA; pcEN=0.
- If both cu_dWEN and cu_dREN are high, the write wins and err_conflict is set.
- On ihit with no data op and no halt: pcEN=1 combinationally this cycle; remain in FETCH.
- ihit with cu_iREN=0 is ignored.
- dhit is ignored in FETCH.

DATA:
- imemREN=0, dmemREN=d_rd, dmemWEN=d_wr. These are registered, so they are first high the cycle after the ihit.
- Requests are held stable until dhit.
- On dhit: pcEN=1 that cycle, d_rd/d_wr clear on the next edge, next state FETCH.
- ihit is ignored in DATA.

HALTED:
- All enables and pcEN are 0; halt=1 from the first cycle in HALTED.
- No exit except RST.

Wait counter and stall_cnt:
- The wait counter increments each cycle a request is asserted without its hit (FETCH with imemREN and !ihit; DATA with !dhit).
- The wait counter clears on a hit or on a state change.
- When the wait counter reaches TIMEOUT, err_timeout=1 (sticky) and the request keeps waiting. No abort.
- stall_cnt increments on the same waiting cycles and saturates at all-ones.

Reset and errors:
- RST asserted mid-DATA drops the dmem enables immediately (asynchronously) and returns to FETCH.
- err_* flags clear only on RST.

Test Plan:
- R-type stream, ihit every cycle, no data ops -> pcEN=1 every cycle, dmem enables never high, stall_cnt=0.
- Load: ihit with cu_dREN=1 -> next cycle dmemREN=1, imemREN=0, pcEN=0; dhit after 3 cycles -> pcEN=1 on the dhit cycle, FETCH next, stall_cnt=3.
- cu_dREN=cu_dWEN=1 on ihit -> dmemWEN=1, dmemREN=0, err_conflict=1 and held.
- HALT on ihit -> halt=1 next cycle, imemREN/pcEN stay 0 for 20 cycles despite ihit pulses; RST -> halt=0, state FETCH.
- Store with dhit withheld 64 cycles (TIMEOUT=64) -> err_timeout rises at wait count 64, dmemWEN stays 1; later dhit -> pcEN=1, err_timeout remains 1.
- RST pulse while dmemREN=1 -> dmemREN=0 asynchronously, all counters and flags cleared, imemREN follows cu_iREN after release.
